// File: rtl/kp_window_ctrl_pkg.sv
// rtl/kp_window_ctrl_pkg.sv - shared state encodings, pixel width and buffer-rotation helper for kp_* blocks
package kp_window_ctrl_pkg;

    localparam int KP_PIX_W = 8;

    typedef enum logic [1:0] {
        KP_S_IDLE = 2'd0,
        KP_S_FILL = 2'd1,
        KP_S_RUN  = 2'd2
    } kp_state_t;

    // Line buffers rotate through indices 0,1,2.
    function automatic logic [1:0] kp_idx_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/kp_linebuf.sv
// rtl/kp_linebuf.sv - one-line pixel buffer, simple dual-port RAM with registered read
module kp_linebuf
    import kp_window_ctrl_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [KP_PIX_W-1:0] i_wdata,
    input  logic                i_re,
    input  logic [AW-1:0]       i_raddr,
    output logic [KP_PIX_W-1:0] o_rdata
);

    logic [KP_PIX_W-1:0] mem [DEPTH];

    // Storage is never reset; the controller only reads locations written earlier in the frame.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/kp_window_ctrl.sv
// rtl/kp_window_ctrl.sv - raster pixel stream to 3x3 window sequencer with border suppression
module kp_window_ctrl
    import kp_window_ctrl_pkg::*;
#(
    parameter int LINE_WIDTH  = 640,
    parameter int FRAME_LINES = 480
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [KP_PIX_W-1:0]   i_data,
    input  logic                  i_valid,
    input  logic                  i_sof,
    output logic [3*KP_PIX_W-1:0] o_r0_data,
    output logic [3*KP_PIX_W-1:0] o_r1_data,
    output logic [3*KP_PIX_W-1:0] o_r2_data,
    output logic                  o_valid,
    output logic                  o_eof,
    output logic                  o_busy
);

    localparam int CW = $clog2(LINE_WIDTH);
    localparam int RW = $clog2(FRAME_LINES);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);

    kp_state_t     state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    wr_idx;

    logic          acc;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic [1:0]    pos_idx;
    logic          col_wrap;
    logic          frame_end;

    logic [KP_PIX_W-1:0] rd [3];
    logic [KP_PIX_W-1:0] rd_old;
    logic [KP_PIX_W-1:0] rd_mid;

    logic                v1;
    logic                w1;
    logic                e1;
    logic [KP_PIX_W-1:0] d1;
    logic [1:0]          idx1;

    logic [2*KP_PIX_W-1:0] sh0;
    logic [2*KP_PIX_W-1:0] sh1;
    logic [2*KP_PIX_W-1:0] sh2;

    // Position of the pixel on the input this cycle; an SOF pixel is always (0,0) into buffer 0.
    always_comb begin
        acc       = i_valid & (i_sof | (state != KP_S_IDLE));
        pos_col   = i_sof ? '0 : col;
        pos_row   = i_sof ? '0 : row;
        pos_idx   = i_sof ? 2'd0 : wr_idx;
        col_wrap  = (pos_col == COL_LAST);
        frame_end = col_wrap && (pos_row == ROW_LAST);
    end

    // Frame sequencer: counters, buffer rotation and busy flag.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state  <= KP_S_IDLE;
            col    <= '0;
            row    <= '0;
            wr_idx <= 2'd0;
            o_busy <= 1'b0;
        end else begin
            // Held through the cycle after the last pixel so a back-to-back SOF sees no dip.
            o_busy <= acc | (state != KP_S_IDLE);
            if (acc) begin
                if (frame_end) begin
                    state  <= KP_S_IDLE;
                    col    <= '0;
                    row    <= '0;
                    wr_idx <= 2'd0;
                end else if (col_wrap) begin
                    col    <= '0;
                    row    <= pos_row + RW'(1);
                    wr_idx <= kp_idx_inc(pos_idx);
                    state  <= (pos_row == '0) ? KP_S_FILL : KP_S_RUN;
                end else begin
                    col    <= pos_col + CW'(1);
                    row    <= pos_row;
                    wr_idx <= pos_idx;
                    if (i_sof) begin
                        state <= KP_S_FILL;
                    end
                end
            end
        end
    end

    // Three rotating line buffers; all read at the current column, only wr_idx written.
    for (genvar g = 0; g < 3; g++) begin : g_lb
        kp_linebuf #(
            .DEPTH (LINE_WIDTH)
        ) u_lb (
            .i_clk   (i_clk),
            .i_we    (acc && (pos_idx == 2'(g))),
            .i_waddr (pos_col),
            .i_wdata (i_data),
            .i_re    (acc),
            .i_raddr (pos_col),
            .o_rdata (rd[g])
        );
    end

    // Pipeline stage aligning the live pixel and its flags with the RAM read data.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            v1   <= 1'b0;
            w1   <= 1'b0;
            e1   <= 1'b0;
            d1   <= '0;
            idx1 <= 2'd0;
        end else begin
            v1 <= acc;
            w1 <= acc && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
            e1 <= acc && frame_end;
            if (acc) begin
                d1   <= i_data;
                idx1 <= pos_idx;
            end
        end
    end

    // Oldest buffer follows the one being written, middle buffer follows that.
    always_comb begin
        rd_old = rd[0];
        rd_mid = rd[1];
        case (idx1)
            2'd0: begin
                rd_old = rd[1];
                rd_mid = rd[2];
            end
            2'd1: begin
                rd_old = rd[2];
                rd_mid = rd[0];
            end
            default: begin
                rd_old = rd[0];
                rd_mid = rd[1];
            end
        endcase
    end

    // Window shift registers keep the two previous columns; outputs load only on a valid window.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sh0       <= '0;
            sh1       <= '0;
            sh2       <= '0;
            o_r0_data <= '0;
            o_r1_data <= '0;
            o_r2_data <= '0;
            o_valid   <= 1'b0;
            o_eof     <= 1'b0;
        end else begin
            o_valid <= w1;
            o_eof   <= e1;
            if (v1) begin
                sh0 <= {sh0[KP_PIX_W-1:0], rd_old};
                sh1 <= {sh1[KP_PIX_W-1:0], rd_mid};
                sh2 <= {sh2[KP_PIX_W-1:0], d1};
            end
            if (w1) begin
                o_r0_data <= {sh0, rd_old};
                o_r1_data <= {sh1, rd_mid};
                o_r2_data <= {sh2, d1};
            end
        end
    end

endmodule

// File: tb/tb_kp_window_ctrl.sv
// tb/tb_kp_window_ctrl.sv - scoreboard bench for kp_window_ctrl
module tb_kp_window_ctrl;

    localparam int LW = 8;
    localparam int FL = 6;
    localparam int NPIX = LW * FL;

    logic        clk;
    logic        rstn;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_sof;
    logic [23:0] o_r0_data;
    logic [23:0] o_r1_data;
    logic [23:0] o_r2_data;
    logic        o_valid;
    logic        o_eof;
    logic        o_busy;

    kp_window_ctrl #(
        .LINE_WIDTH  (LW),
        .FRAME_LINES (FL)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_sof     (i_sof),
        .o_r0_data (o_r0_data),
        .o_r1_data (o_r1_data),
        .o_r2_data (o_r2_data),
        .o_valid   (o_valid),
        .o_eof     (o_eof),
        .o_busy    (o_busy)
    );

    typedef struct {
        logic [23:0] r0;
        logic [23:0] r1;
        logic [23:0] r2;
        logic        eof;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          windows_seen = 0;
    int          eof_seen = 0;
    bit          busy_watch = 0;
    bit          cap_first = 0;
    logic [23:0] first_r0, first_r1, first_r2, last_r2;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [7:0] pv(input logic [7:0] base, input int r, input int c);
        return base + 8'(r * 16 + c);
    endfunction

    function automatic logic [23:0] rowword(input logic [7:0] base, input int r, input int c);
        return {pv(base, r, c - 2), pv(base, r, c - 1), pv(base, r, c)};
    endfunction

    // Output monitor: pops the scoreboard on every window
    always @(negedge clk) begin
        exp_t e;
        if (o_valid) begin
            windows_seen++;
            if (o_eof) eof_seen++;
            last_r2 = o_r2_data;
            if (cap_first) begin
                first_r0 = o_r0_data;
                first_r1 = o_r1_data;
                first_r2 = o_r2_data;
                cap_first = 0;
            end
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_window: got r0=%h r1=%h r2=%h at cyc %0d, required none", o_r0_data, o_r1_data, o_r2_data, cyc);
            end else begin
                e = q.pop_front();
                if ({o_r0_data, o_r1_data, o_r2_data} !== {e.r0, e.r1, e.r2}) begin
                    miscompares++;
                    $display("FAIL window_data: got %h %h %h, required %h %h %h", o_r0_data, o_r1_data, o_r2_data, e.r0, e.r1, e.r2);
                end
                vectors++;
                if (o_eof !== e.eof) begin
                    miscompares++;
                    $display("FAIL window_eof: got %b, required %b (r2=%h)", o_eof, e.eof, e.r2);
                end
                vectors++;
                if (cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL window_latency: got cyc %0d, required cyc %0d (r2=%h)", cyc, e.cyc, e.r2);
                end
            end
        end else if (o_eof !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL eof_without_valid: got o_eof=%b, required 0 at cyc %0d", o_eof, cyc);
        end
        if (busy_watch) begin
            vectors++;
            if (o_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_hold: got o_busy=%b, required 1 at cyc %0d", o_busy, cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            i_valid = 0;
            i_sof   = 0;
        end
    endtask

    task automatic drive_pix(input logic [7:0] base, input int r, input int c, input bit sof);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid = 1;
        i_sof   = sof;
        i_data  = pv(base, r, c);
        if (r >= 2 && c >= 2) begin
            e.r0  = rowword(base, r - 2, c);
            e.r1  = rowword(base, r - 1, c);
            e.r2  = rowword(base, r, c);
            e.eof = (r == FL - 1) && (c == LW - 1);
            e.cyc = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic drive_range(input logic [7:0] base, input int first, input int last, input bit gaps);
        for (int k = first; k < last; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            drive_pix(base, k / LW, k % LW, k == 0);
        end
    endtask

    task automatic drive_junk(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            i_valid = 1;
            i_sof   = 0;
            i_data  = 8'hE0 + 8'(k);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d windows outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_counts(input string name, input int w0, input int e0, input int wexp, input int eexp);
        vectors++;
        if (windows_seen - w0 !== wexp) begin
            miscompares++;
            $display("FAIL %s_window_count: got %0d, required %0d", name, windows_seen - w0, wexp);
        end
        vectors++;
        if (eof_seen - e0 !== eexp) begin
            miscompares++;
            $display("FAIL %s_eof_count: got %0d, required %0d", name, eof_seen - e0, eexp);
        end
    endtask

    task automatic test_reset;
        rstn = 0; i_valid = 0; i_sof = 0; i_data = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        vectors++;
        if ({o_r0_data, o_r1_data, o_r2_data, o_valid, o_eof, o_busy} !== 75'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h %h %h v=%b e=%b b=%b, required all 0", o_r0_data, o_r1_data, o_r2_data, o_valid, o_eof, o_busy);
        end
    endtask

    task automatic test_continuous;
        int w0 = windows_seen, e0 = eof_seen;
        cap_first = 1;
        drive_range(8'h00, 0, NPIX, 0);
        idle(1);
        drain("continuous");
        check_counts("continuous", w0, e0, 24, 1);
        vectors++;
        if ({first_r0, first_r1, first_r2} !== {24'h000102, 24'h101112, 24'h202122}) begin
            miscompares++;
            $display("FAIL first_window: got %h %h %h, required 000102 101112 202122", first_r0, first_r1, first_r2);
        end
        vectors++;
        if (last_r2 !== 24'h555657) begin
            miscompares++;
            $display("FAIL last_window_r2: got %h, required 555657", last_r2);
        end
        idle(2);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_frame: got %b, required 0", o_busy);
        end
    endtask

    task automatic test_gaps;
        int w0 = windows_seen, e0 = eof_seen;
        drive_range(8'h00, 0, NPIX, 1);
        idle(1);
        drain("gaps");
        check_counts("gaps", w0, e0, 24, 1);
    endtask

    task automatic test_pre_sof;
        int w0 = windows_seen, e0 = eof_seen;
        drive_junk(10);
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_sof_busy: got %b, required 0", o_busy);
        end
        drive_range(8'h00, 0, NPIX, 0);
        idle(1);
        drain("pre_sof");
        check_counts("pre_sof", w0, e0, 24, 1);
    endtask

    task automatic test_abort;
        int w0 = windows_seen, e0 = eof_seen;
        drive_range(8'h80, 0, 3 * LW + 4, 0);
        drive_range(8'h00, 0, NPIX, 0);
        idle(1);
        drain("abort");
        check_counts("abort", w0, e0, 8 + 24, 1);
    endtask

    task automatic test_reset_mid_frame;
        int w0 = windows_seen, e0 = eof_seen;
        int m;
        drive_range(8'h00, 0, 4 * LW + 3, 0);
        @(posedge clk);
        #1;
        rstn = 0; i_valid = 1; i_sof = 0; i_data = pv(8'h00, 4, 3);
        m = cyc;
        while (q.size() > 0 && q[$].cyc > m) void'(q.pop_back());
        @(posedge clk);
        #1;
        rstn = 1; i_valid = 0;
        @(negedge clk);
        vectors++;
        if ({o_r0_data, o_r1_data, o_r2_data, o_valid, o_eof, o_busy} !== 75'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h %h %h v=%b e=%b b=%b, required all 0", o_r0_data, o_r1_data, o_r2_data, o_valid, o_eof, o_busy);
        end
        drive_junk(5);
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_drop_busy: got %b, required 0", o_busy);
        end
        drive_range(8'h00, 0, NPIX, 0);
        idle(1);
        drain("mid_reset");
        check_counts("mid_reset", w0, e0, 12 + 24, 1);
    endtask

    task automatic test_back_to_back;
        int w0 = windows_seen, e0 = eof_seen;
        drive_range(8'h40, 0, 2, 0);
        busy_watch = 1;
        drive_range(8'h40, 2, NPIX, 0);
        drive_range(8'h00, 0, NPIX - 1, 0);
        busy_watch = 0;
        drive_range(8'h00, NPIX - 1, NPIX, 0);
        idle(1);
        drain("back_to_back");
        check_counts("back_to_back", w0, e0, 48, 2);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_pre_sof();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
